// File: rtl/mode_counter.sv
// mode_counter
//   Parametrised multi-mode counter: binary up, binary down, Gray-coded up,
//   and Johnson. It has a synchronous load that clamps to the modulus, a count
//   enable, optional saturation, a terminal-count level and a wrap pulse.
//
// Parameters
//   WIDTH    counter width, 2..16
//   MODULUS  number of states for modes 0-2, 2..2^WIDTH
//   SATURATE 1 = hold at the end value instead of wrapping (modes 0-2)
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   en        count enable
//   mode      00 up, 01 down, 10 Gray up, 11 Johnson
//   load      synchronous load strobe
//   load_val  load value (clamped to MODULUS-1 in modes 0-2)
//   cnt       count output, decoded from registers only
//   tc        terminal-count level
//   wrap      one-cycle pulse while cnt shows the post-wrap value
module mode_counter #(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrap
);

  typedef enum logic [1:0] {
    M_UP   = 2'b00,
    M_DN   = 2'b01,
    M_GRAY = 2'b10,
    M_JOHN = 2'b11
  } mode_e;

  typedef struct packed {
    mode_e            mode_q;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] jr;
    logic             wrap;
  } state_t;

  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);
  // Last Johnson state before the all-zero state.
  localparam logic [WIDTH-1:0] JLAST = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  state_t st, st_d;

  // Priority: mode change > load > en > hold.
  always_comb begin
    st_d      = st;
    st_d.wrap = 1'b0;
    if (mode_e'(mode) != st.mode_q) begin
      // A mode switch restarts the sequence; load and en are ignored.
      st_d.mode_q = mode_e'(mode);
      st_d.bin    = '0;
      st_d.jr     = '0;
    end else if (load) begin
      if (st.mode_q == M_JOHN) st_d.jr  = load_val;
      else                     st_d.bin = (load_val > LAST) ? LAST : load_val;
    end else if (en) begin
      case (st.mode_q)
        M_JOHN: begin
          // Illegal loaded patterns are left to cycle in their own orbit.
          st_d.jr   = {st.jr[WIDTH-2:0], ~st.jr[WIDTH-1]};
          st_d.wrap = (st.jr == JLAST);
        end
        M_DN: begin
          if (st.bin == '0) begin
            if (!SATURATE) begin
              st_d.bin  = LAST;
              st_d.wrap = 1'b1;
            end
          end else begin
            st_d.bin = st.bin - ONE;
          end
        end
        default: begin  // up and Gray share the binary up count
          if (st.bin == LAST) begin
            if (!SATURATE) begin
              st_d.bin  = '0;
              st_d.wrap = 1'b1;
            end
          end else begin
            st_d.bin = st.bin + ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st.mode_q <= M_UP;
      st.bin    <= '0;
      st.jr     <= '0;
      st.wrap   <= 1'b0;
    end else begin
      st <= st_d;
    end
  end

  // Output decode sees registered state only; reset state decodes to
  // cnt = 0 and tc = 0 since MODULUS >= 2.
  always_comb begin
    cnt = st.bin;
    tc  = 1'b0;
    case (st.mode_q)
      M_UP:   tc  = (st.bin == LAST);
      M_DN:   tc  = (st.bin == '0);
      M_GRAY: begin
        cnt = st.bin ^ (st.bin >> 1);
        tc  = (st.bin == LAST);
      end
      M_JOHN: begin
        cnt = st.jr;
        tc  = (st.jr == JLAST);
      end
      default: ;
    endcase
  end

  assign wrap = st.wrap;

endmodule

// File: tb/tb_mode_counter.sv
// Scoreboard bench for mode_counter. Four instances with different
// parameters share one stimulus stream; a behavioural model pushes the
// expected outputs of every instance after each edge and a monitor on the
// falling edge pops and compares them.
module tb_mode_counter;

  localparam int N = 4;
  localparam int PW [N] = '{3, 3, 3, 4};
  localparam int PM [N] = '{8, 6, 8, 10};
  localparam int PS [N] = '{0, 0, 1, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, load = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] lv = '0;

  logic [2:0] c0, c1, c2;
  logic [3:0] c3;
  logic       t0, t1, t2, t3, w0, w1, w2, w3;

  always #5 clk = ~clk;

  mode_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_val(lv[2:0]), .cnt(c0), .tc(t0), .wrap(w0));
  mode_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b0)) u1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_val(lv[2:0]), .cnt(c1), .tc(t1), .wrap(w1));
  mode_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b1)) u2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_val(lv[2:0]), .cnt(c2), .tc(t2), .wrap(w2));
  mode_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_val(lv), .cnt(c3), .tc(t3), .wrap(w3));

  typedef struct {
    int inst;
    int c;
    int t;
    int w;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Reference state: integer count, Johnson pattern, current mode, wrap.
  int mbin [N];
  int mjr  [N];
  int mmq  [N];
  int mwr  [N];

  function automatic int act_cnt(int i);
    case (i)
      0: return int'(c0);
      1: return int'(c1);
      2: return int'(c2);
      default: return int'(c3);
    endcase
  endfunction

  function automatic int act_tc(int i);
    case (i)
      0: return int'(t0);
      1: return int'(t1);
      2: return int'(t2);
      default: return int'(t3);
    endcase
  endfunction

  function automatic int act_wr(int i);
    case (i)
      0: return int'(w0);
      1: return int'(w1);
      2: return int'(w2);
      default: return int'(w3);
    endcase
  endfunction

  function automatic int exp_cnt(int i);
    case (mmq[i])
      2: return mbin[i] ^ (mbin[i] >> 1);
      3: return mjr[i];
      default: return mbin[i];
    endcase
  endfunction

  function automatic int exp_tc(int i);
    case (mmq[i])
      1: return int'(mbin[i] == 0);
      3: return int'(mjr[i] == (1 << (PW[i] - 1)));
      default: return int'(mbin[i] == PM[i] - 1);
    endcase
  endfunction

  task automatic chk(input string name, input int inst, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s inst%0d @%0t: got %0d expected %0d", name, inst, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mbin[i] = 0; mjr[i] = 0; mmq[i] = 0; mwr[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input int e, input int md, input int ld, input int v);
    int mask, lim;
    mask = (1 << PW[i]) - 1;
    lim  = PM[i] - 1;
    mwr[i] = 0;
    if (md != mmq[i]) begin
      mmq[i] = md; mbin[i] = 0; mjr[i] = 0;
    end else if (ld != 0) begin
      if (mmq[i] == 3) mjr[i] = v & mask;
      else mbin[i] = ((v & mask) > lim) ? lim : (v & mask);
    end else if (e != 0) begin
      if (mmq[i] == 3) begin
        mwr[i] = int'(mjr[i] == (1 << (PW[i] - 1)));
        mjr[i] = ((mjr[i] << 1) | (((mjr[i] >> (PW[i] - 1)) & 1) ^ 1)) & mask;
      end else if (mmq[i] == 1) begin
        if (mbin[i] == 0) begin
          if (PS[i] == 0) begin mbin[i] = lim; mwr[i] = 1; end
        end else mbin[i] = mbin[i] - 1;
      end else begin
        if (mbin[i] == lim) begin
          if (PS[i] == 0) begin mbin[i] = 0; mwr[i] = 1; end
        end else mbin[i] = mbin[i] + 1;
      end
    end
  endtask

  // One clock cycle of stimulus; expectations are queued after the edge.
  task automatic cyc(input int e, input int md, input int ld, input int v);
    en = e[0]; mode = md[1:0]; load = ld[0]; lv = v[3:0];
    for (int i = 0; i < N; i++) model_step(i, e, md, ld, v);
    @(posedge clk);
    for (int i = 0; i < N; i++) q.push_back('{i, exp_cnt(i), exp_tc(i), mwr[i]});
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("cnt",  x.inst, act_cnt(x.inst), x.c);
      chk("tc",   x.inst, act_tc(x.inst),  x.t);
      chk("wrap", x.inst, act_wr(x.inst),  x.w);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < N; i++) begin
      chk({tag, "_cnt"},  i, act_cnt(i), 0);
      chk({tag, "_tc"},   i, act_tc(i),  0);
      chk({tag, "_wrap"}, i, act_wr(i),  0);
    end
  endtask

  initial begin
    int md;
    model_reset();
    #2 rst = 1'b0;
    #1 chk_reset_outputs("reset");
    @(negedge clk); #2 rst = 1'b1;

    // Up count including wrap, and saturation on instance 2.
    for (int k = 0; k < 12; k++) cyc(1, 0, 0, 0);
    chk("sat_hold_cnt", 2, act_cnt(2), 7);
    chk("sat_hold_tc",  2, act_tc(2),  1);

    // Down count; first edge is the mode switch.
    for (int k = 0; k < 8; k++) cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 7);  // load wins over en; clamps on MODULUS=6
    chk("clamp_load", 1, act_cnt(1), 5);

    // Johnson, then Gray.
    for (int k = 0; k < 7; k++) cyc(1, 3, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 2, 0, 0);
    chk("gray_seq", 0, act_cnt(0), 6);

    // Asynchronous reset in the middle of an up count.
    for (int k = 0; k < 6; k++) cyc(1, 0, 0, 0);
    @(negedge clk); #2;
    chk("pre_reset", 0, act_cnt(0), 5);
    rst = 1'b0;
    model_reset();
    #1 chk_reset_outputs("async_reset");
    @(negedge clk); #2 rst = 1'b1;
    for (int k = 0; k < 7; k++) cyc(1, 0, 0, 0);
    chk("pre_load", 0, act_cnt(0), 7);
    cyc(1, 0, 1, 3);
    chk("load_over_en_cnt",  0, act_cnt(0), 3);
    chk("load_over_en_wrap", 0, act_wr(0),  0);

    // Randomised traffic.
    md = 0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(15) == 0) md = int'($urandom_range(3));
      cyc(int'($urandom_range(3) != 0), md, int'($urandom_range(7) == 0),
          int'($urandom_range(15)));
    end
    en = 1'b0; load = 1'b0;

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
